// File: rtl/fdivsqrt_iter_ctrl_pkg.sv
// Shared types for the div/sqrt iteration controller: core config slice and FSM states.
package fdivsqrt_iter_ctrl_pkg;
  typedef struct packed {
    int unsigned DURLEN;
    int unsigned DIVCOPIES;
  } cvw_t;

  localparam cvw_t CVW_DEFAULT = '{DURLEN: 6, DIVCOPIES: 2};

  typedef enum logic [1:0] {DS_IDLE, DS_BUSY, DS_DONE} divsqrt_state_t;
endpackage

// File: rtl/fdivsqrt_iter_ctrl_downcount.sv
// Loadable down-counter that saturates at zero; holds remaining recurrence steps minus one.
module fdivsqrt_downcount #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         zero
);
  localparam logic [W-1:0] ONE = 1;

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     r_cnt <= '0;
    else if (load)                 r_cnt <= d;
    else if (dec && r_cnt != '0)   r_cnt <= r_cnt - ONE;
  end

  assign q    = r_cnt;
  assign zero = (r_cnt == '0);
endmodule

// File: rtl/fdivsqrt_iter_ctrl.sv
// Steps the div/sqrt recurrence CyclesE times per accepted op; drives init/iterate/busy/done.
module fdivsqrt_iter_ctrl
  import fdivsqrt_iter_ctrl_pkg::*;
#(
  parameter cvw_t P = CVW_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                StartE,
  input  logic [P.DURLEN-1:0] CyclesE,
  input  logic                SpecialE,
  input  logic                FlushE,
  input  logic                StallM,
  output logic                InitE,
  output logic                IterEnE,
  output logic                BusyE,
  output logic                DoneE,
  output logic [P.DURLEN-1:0] CountE
);
  localparam int W = P.DURLEN;
  localparam logic [W-1:0] ONE = 1;

  divsqrt_state_t r_state, w_next;
  logic           w_accept, w_zero, w_load, w_dec;
  logic [W-1:0]   w_cycm1, w_ld_val;

  // Combinational outputs must also read 0 while reset is asserted.
  assign w_accept = StartE & ~FlushE & ~reset &
                    ((r_state == DS_IDLE) | ((r_state == DS_DONE) & ~StallM));
  assign w_cycm1  = (CyclesE == '0) ? '0 : CyclesE - ONE;
  assign w_load   = FlushE | (w_accept & ~SpecialE);
  assign w_ld_val = FlushE ? '0 : w_cycm1;
  assign w_dec    = (r_state == DS_BUSY);

  fdivsqrt_downcount #(.W(W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .dec   (w_dec),
    .d     (w_ld_val),
    .q     (CountE),
    .zero  (w_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= DS_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    InitE   = w_accept;
    IterEnE = 1'b0;
    BusyE   = w_accept;
    DoneE   = 1'b0;
    case (r_state)
      DS_IDLE: if (w_accept) w_next = SpecialE ? DS_DONE : DS_BUSY;
      DS_BUSY: begin
        IterEnE = 1'b1;
        BusyE   = 1'b1;
        if (w_zero) w_next = DS_DONE;
      end
      DS_DONE: begin
        DoneE = 1'b1;
        if (StallM)        BusyE  = 1'b1;
        else if (w_accept) w_next = SpecialE ? DS_DONE : DS_BUSY;
        else               w_next = DS_IDLE;
      end
      default: w_next = DS_IDLE;
    endcase
    // Flush squashes the in-flight op; DoneE keeps reflecting the current state.
    if (FlushE) begin
      w_next  = DS_IDLE;
      IterEnE = 1'b0;
      BusyE   = 1'b0;
    end
  end
endmodule

// File: tb/tb_fdivsqrt_iter_ctrl.sv
// Directed bench for fdivsqrt_iter_ctrl: scoreboard of expected iteration count and done latency.
module tb_fdivsqrt_iter_ctrl;
  import fdivsqrt_iter_ctrl_pkg::*;
  localparam int W = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         StartE = 1'b0, SpecialE = 1'b0, FlushE = 1'b0, StallM = 1'b0;
  logic [W-1:0] CyclesE = '0;
  logic         InitE, IterEnE, BusyE, DoneE;
  logic [W-1:0] CountE;

  typedef struct {
    int    iters;
    int    lat;
    string tag;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  fdivsqrt_iter_ctrl #(.P('{DURLEN: W, DIVCOPIES: 2})) dut (
    .clk(clk), .reset(reset), .StartE(StartE), .CyclesE(CyclesE), .SpecialE(SpecialE),
    .FlushE(FlushE), .StallM(StallM), .InitE(InitE), .IterEnE(IterEnE), .BusyE(BusyE),
    .DoneE(DoneE), .CountE(CountE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; checks run 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle start; optionally push the expected outcome to the scoreboard.
  task automatic start(input string tag, input int cyc, input bit spec, input bit push);
    exp_t e;
    int   n;
    StartE = 1'b1; CyclesE = W'(cyc); SpecialE = spec;
    #1;
    check({tag, ".init"}, InitE, 1);
    check({tag, ".busy_t"}, BusyE, 1);
    n = spec ? 0 : (cyc == 0 ? 1 : cyc);
    e.iters = n; e.lat = n + 1; e.tag = tag;
    if (push) sb.push_back(e);
    tick();
    StartE = 1'b0; SpecialE = 1'b0;
    CyclesE = W'($urandom_range(0, 63));
    #1;
    if (!spec) check({tag, ".count0"}, CountE, n - 1);
  endtask

  // Observe from cycle t+1 until DoneE; compare against the scoreboard head.
  task automatic drain(input int budget);
    exp_t e;
    int   iters = 0;
    bit   seen = 0;
    e = sb.pop_front();
    for (int k = 1; k <= budget; k++) begin
      if (IterEnE) begin
        iters++;
        if (BusyE !== 1'b1) check({e.tag, ".busy_iter"}, BusyE, 1);
      end
      if (DoneE) begin
        check({e.tag, ".iters"}, iters, e.iters);
        check({e.tag, ".lat"}, k, e.lat);
        check({e.tag, ".busy_done"}, BusyE, StallM);
        seen = 1;
        break;
      end
      tick();
    end
    if (!seen) check({e.tag, ".timeout"}, 0, 1);
  endtask

  initial begin
    #2;
    check("rst.init", InitE, 0);
    check("rst.iter", IterEnE, 0);
    check("rst.busy", BusyE, 0);
    check("rst.done", DoneE, 0);
    check("rst.count", CountE, 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // 1: nominal 14 iterations
    start("c14", 14, 0, 1); drain(40); tick();
    // 2: zero and one iteration counts behave alike
    start("c0", 0, 0, 1); drain(10); tick();
    start("c1", 1, 0, 1); drain(10); tick();
    // 3: special operand bypasses the recurrence
    start("spec", 30, 1, 1); drain(5); tick();

    // 4: flush on the 5th iteration
    start("flush", 20, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    FlushE = 1'b1; #1;
    check("flush.iter", IterEnE, 0);
    check("flush.busy", BusyE, 0);
    tick(); FlushE = 1'b0; #1;
    check("flush.count", CountE, 0);
    check("flush.busy2", BusyE, 0);
    for (int i = 0; i < 20; i++) begin
      if (DoneE || IterEnE) check("flush.nodone", {DoneE, IterEnE}, 0);
      tick();
    end
    start("restart3", 3, 0, 1); drain(10); tick();

    // 5: stalled result, ignored start, then back-to-back accept
    StallM = 1'b1;
    start("stall", 2, 0, 1); drain(10);
    tick();
    StartE = 1'b1; CyclesE = 6'd9; #1;
    for (int i = 0; i < 2; i++) begin
      check("stall.done", DoneE, 1);
      check("stall.busy", BusyE, 1);
      check("stall.noinit", InitE, 0);
      tick();
    end
    StallM = 1'b0;
    start("b2b", 4, 0, 1);
    drain(10); tick();

    // 6: async reset mid-operation
    start("arst", 10, 0, 0);
    tick(); tick();
    #2 reset = 1'b1; StartE = 1'b1; #1;
    check("arst.iter", IterEnE, 0);
    check("arst.busy", BusyE, 0);
    check("arst.init", InitE, 0);
    check("arst.count", CountE, 0);
    StartE = 1'b0;
    #1 reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (DoneE || IterEnE || BusyE) check("arst.idle", {DoneE, IterEnE, BusyE}, 0);
    end
    check("arst.final", {DoneE, IterEnE, BusyE}, 0);
    check("sb.empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
